// File: rtl/load_extend_pkg.sv
// Shared size encodings, lane width and offset-width helper for the load extend unit.
package load_extend_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int LANE_W = 8;

  // Number of byte-offset bits needed to address every lane of an xlen-bit word.
  function automatic int offset_width(input int xlen);
    return $clog2(xlen / LANE_W);
  endfunction

endpackage

// File: rtl/load_extend_fmt.sv
// Combinational lane extract / sign-or-zero extend plus misalignment decode.
// Optional alignment check enabled by LOAD_EXTEND_MISALIGN_CHECK_EN.
module load_extend_fmt
  import load_extend_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = offset_width(XLEN)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [OW-1:0]   addr_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] res_o,
  output logic            misalign_o
);

  localparam int SW = OW + 3;

  logic [OW-1:0]   mask_lo;
  logic [OW-1:0]   addr_eff;
  logic [SW-1:0]   shamt;
  logic [SW-1:0]   msb_idx;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic            full;
  logic            sign;

  always_comb begin
    mask_lo = '0;
    for (int i = 0; i < OW; i++) begin
      mask_lo[i] = (i < int'(size_i));
    end
    full     = (int'(size_i) >= OW);
    // Aligned accesses are unaffected by the mask; misaligned ones snap down to the size boundary.
    addr_eff = addr_i & ~mask_lo;
    shamt    = {addr_eff, 3'b000};
    shifted  = data_i >> shamt;
    case (size_i)
      SZ_BYTE:  msb_idx = SW'(7);
      SZ_HALF:  msb_idx = SW'(15);
      SZ_WORD:  msb_idx = SW'(31);
      SZ_DWORD: msb_idx = SW'(63);
      default:  msb_idx = SW'(7);
    endcase
    sign = shifted[msb_idx] & ~uns_i;
  end

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
    assign ext[gi] = (gi <= int'(msb_idx)) ? shifted[gi] : sign;
  end

  always_comb begin
    res_o = full ? data_i : ext;
`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
    misalign_o = !full && ((addr_i & mask_lo) != '0);
    if (misalign_o) begin
      res_o = '0;
    end
`else
    misalign_o = 1'b0;
`endif
  end

endmodule

// File: rtl/load_extend_unit.sv
// Two-stage valid/ready load-data formatter (raw request in A, formatted result in B).
// Alignment checking and the saturating misalignment counter exist only with LOAD_EXTEND_MISALIGN_CHECK_EN.
module load_extend_unit
  import load_extend_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16,
  localparam int OW   = offset_width(XLEN)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [XLEN-1:0]  InData,
  input  logic [OW-1:0]    InAddrLo,
  input  logic [1:0]       InSize,
  input  logic             InUnsigned,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  OutData,
  output logic [TAG_W-1:0] OutTag,
  output logic             OutMisalign,
  output logic [CNT_W-1:0] MisalignCnt
);

  logic             a_valid_q, a_valid_d;
  logic [XLEN-1:0]  a_data_q, a_data_d;
  logic [OW-1:0]    a_addr_q, a_addr_d;
  logic [1:0]       a_size_q, a_size_d;
  logic             a_uns_q, a_uns_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  logic             b_valid_q, b_valid_d;
  logic [XLEN-1:0]  b_data_q, b_data_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic             b_mis_q, b_mis_d;

  logic             b_load;
  logic             a_load;
  logic [XLEN-1:0]  fmt_res;
  logic             fmt_mis;

  load_extend_fmt #(.XLEN(XLEN)) u_fmt (
    .data_i     (a_data_q),
    .addr_i     (a_addr_q),
    .size_i     (a_size_q),
    .uns_i      (a_uns_q),
    .res_o      (fmt_res),
    .misalign_o (fmt_mis)
  );

  // Ready ripples back combinationally so a full pipe still streams one per cycle.
  assign b_load  = !b_valid_q || OutReady;
  assign a_load  = !a_valid_q || b_load;
  assign InReady = a_load;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_addr_d  = a_addr_q;
    a_size_d  = a_size_q;
    a_uns_d   = a_uns_q;
    a_tag_d   = a_tag_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_tag_d   = b_tag_q;
    b_mis_d   = b_mis_q;
    if (a_load) begin
      a_valid_d = InValid;
      if (InValid) begin
        a_data_d = InData;
        a_addr_d = InAddrLo;
        a_size_d = InSize;
        a_uns_d  = InUnsigned;
        a_tag_d  = InTag;
      end
    end
    if (b_load) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_data_d = fmt_res;
        b_tag_d  = a_tag_q;
        b_mis_d  = fmt_mis;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_addr_q  <= '0;
      a_size_q  <= '0;
      a_uns_q   <= 1'b0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_tag_q   <= '0;
      b_mis_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_addr_q  <= a_addr_d;
      a_size_q  <= a_size_d;
      a_uns_q   <= a_uns_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_tag_q   <= b_tag_d;
      b_mis_q   <= b_mis_d;
    end
  end

  assign OutValid    = b_valid_q;
  assign OutData     = b_data_q;
  assign OutTag      = b_tag_q;
  assign OutMisalign = b_mis_q;

`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (b_load && a_valid_q && fmt_mis && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign MisalignCnt = cnt_q;
`else
  assign MisalignCnt = '0;
`endif

endmodule

// File: tb/tb_load_extend_unit.sv
// Randomised scoreboard bench for load_extend_unit (XLEN=32) plus a short XLEN=64 pass-through check.
module tb_load_extend_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InValid, InReady, InUnsigned, OutValid, OutReady, OutMisalign;
  logic [31:0] InData, OutData;
  logic [1:0]  InAddrLo, InSize;
  logic [4:0]  InTag, OutTag;
  logic [15:0] MisalignCnt;

  logic        v64, r64, u64s, ov64, or64, om64;
  logic [63:0] d64, od64;
  logic [2:0]  a64;
  logic [1:0]  s64;
  logic [4:0]  t64, ot64;
  logic [15:0] mc64;

  always #5 Clk = ~Clk;

  load_extend_unit #(.XLEN(32), .TAG_W(5), .CNT_W(16)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady), .InData(InData),
    .InAddrLo(InAddrLo), .InSize(InSize), .InUnsigned(InUnsigned), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutTag(OutTag),
    .OutMisalign(OutMisalign), .MisalignCnt(MisalignCnt)
  );

  load_extend_unit #(.XLEN(64), .TAG_W(5), .CNT_W(16)) u_dut64 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(v64), .InReady(r64), .InData(d64),
    .InAddrLo(a64), .InSize(s64), .InUnsigned(u64s), .InTag(t64),
    .OutValid(ov64), .OutReady(or64), .OutData(od64), .OutTag(ot64),
    .OutMisalign(om64), .MisalignCnt(mc64)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned mdl_cnt = 0;
  int          acc_total = 0;
  bit          bp_arm = 0;
  int          bp_base = 0;
  int          bp_seen = -1;
  bit          rnd_ready = 0;

  // Reference: pick the byte lanes arithmetically, then two's-complement wrap if signed.
  function automatic logic [31:0] model(input logic [31:0] d, input int off, input int size,
                                        input bit uns, output bit mis);
    int nb;
    longint unsigned v, lim;
    nb  = 1 << size;
    mis = 0;
    if (nb >= 4) return d;
    mis = (off % nb) != 0;
`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
    if (mis) return 32'h0;
`else
    mis = 0;
    off = off - (off % nb);
`endif
    lim = 64'd1 << (8 * nb);
    v   = ({32'd0, d} >> (8 * off)) % lim;
    if (!uns && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  logic        hold_prev = 0;
  logic [31:0] prev_data;
  logic [4:0]  prev_tag;
  logic        prev_mis;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      hold_prev = 0;
    end else begin
      exp_t e;
      bit   m;
      if (hold_prev) begin
        chk("hold_data", OutData, prev_data);
        chk("hold_tag", OutTag, prev_tag);
        chk("hold_mis", OutMisalign, prev_mis);
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          chk("spurious_output", {59'd0, OutTag}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("out_data", OutData, e.data);
          chk("out_tag", OutTag, e.tag);
          chk("out_mis", OutMisalign, e.mis);
          $display("out tag=%0d data=%h mis=%0d", OutTag, OutData, OutMisalign);
        end
      end
      hold_prev = OutValid && !OutReady;
      prev_data = OutData;
      prev_tag  = OutTag;
      prev_mis  = OutMisalign;
      if (bp_arm && InValid && !InReady) begin
        bp_seen = acc_total - bp_base;
        bp_arm  = 0;
      end
      if (InValid && InReady) begin
        e.data = model(InData, int'(InAddrLo), int'(InSize), InUnsigned, m);
        e.tag  = InTag;
        e.mis  = m;
        sb.push_back(e);
        if (m && mdl_cnt < 32'hFFFF) mdl_cnt++;
        acc_total++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                      input logic un, input logic [4:0] tg);
    bit acc = 0;
    InData = d; InAddrLo = off; InSize = sz; InUnsigned = un; InTag = tg; InValid = 1'b1;
    for (int n = 0; n < 1000 && !acc; n++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
    end
    InValid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: tag %0d never accepted", tg);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge Clk);
      n++;
    end
    @(posedge Clk);
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (rnd_ready) OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit          m;
    logic [63:0] w;
    Rst_n = 1'b0; InValid = 0; InData = 0; InAddrLo = 0; InSize = 0; InUnsigned = 0; InTag = 0;
    OutReady = 1'b1;
    v64 = 0; d64 = 0; a64 = 0; s64 = 0; u64s = 0; t64 = 0; or64 = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_outdata", OutData, 0);
    chk("rst_outtag", OutTag, 0);
    chk("rst_outmis", OutMisalign, 0);
    chk("rst_cnt", MisalignCnt, 0);
    chk("rst_inready", InReady, 1);
    Rst_n = 1'b1;

    // Model pins against hand-computed values.
    chk("pin_b1s", model(32'h80F17F23, 1, 0, 0, m), 32'h0000007F);
    chk("pin_b2s", model(32'h80F17F23, 2, 0, 0, m), 32'hFFFFFFF1);
    chk("pin_b2u", model(32'h80F17F23, 2, 0, 1, m), 32'h000000F1);
    chk("pin_h2s", model(32'h80F17F23, 2, 1, 0, m), 32'hFFFF80F1);
    chk("pin_h2u", model(32'h80F17F23, 2, 1, 1, m), 32'h000080F1);
    chk("pin_w0u", model(32'h80F17F23, 0, 2, 1, m), 32'h80F17F23);
`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
    chk("pin_h3", model(32'h12345678, 3, 1, 0, m), 32'h00000000);
    chk("pin_h3_mis", m, 1);
`else
    chk("pin_h3", model(32'h12345678, 3, 1, 0, m), 32'h00001234);
`endif

    send(32'h80F17F23, 2'd1, 2'd0, 1'b0, 5'd1);
    send(32'h80F17F23, 2'd2, 2'd0, 1'b0, 5'd2);
    send(32'h80F17F23, 2'd2, 2'd0, 1'b1, 5'd3);
    send(32'h80F17F23, 2'd2, 2'd1, 1'b0, 5'd4);
    send(32'h80F17F23, 2'd2, 2'd1, 1'b1, 5'd5);
    send(32'h80F17F23, 2'd0, 2'd2, 1'b1, 5'd6);
    send(32'h12345678, 2'd3, 2'd1, 1'b0, 5'd7);
    drain();
`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
    chk("cnt_after_one", MisalignCnt, 16'd1);
`else
    chk("cnt_after_one", MisalignCnt, 16'd0);
`endif

    // XLEN=64 pass-through and word extraction.
    w = {$urandom, $urandom};
    d64 = w; a64 = 3'($urandom_range(0, 7)); s64 = 2'd3; u64s = 0; t64 = 5'd11; v64 = 1;
    @(posedge Clk); #1; v64 = 0;
    @(posedge Clk); #1;
    chk("x64_dword_valid", ov64, 1);
    chk("x64_dword_data", od64, w);
    d64 = {32'h80000000, 32'h12345678}; a64 = 3'd4; s64 = 2'd2; v64 = 1;
    @(posedge Clk); #1; v64 = 0;
    @(posedge Clk); #1;
    chk("x64_word_data", od64, 64'hFFFFFFFF80000000);
    $display("x64 checks done tag=%0d", ot64);

    // Backpressure: four back-to-back requests with OutReady low for three cycles.
    OutReady = 1'b0;
    bp_base = acc_total; bp_seen = -1; bp_arm = 1;
    fork
      begin
        for (int t = 0; t < 4; t++) send($urandom, 2'd0, 2'd2, 1'b1, 5'(t));
      end
      begin
        repeat (3) @(posedge Clk);
        #1 OutReady = 1'b1;
      end
    join
    drain();
    bp_arm = 0;
    chk("bp_accepts_before_stall", bp_seen, 2);

    // Randomised traffic with random backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    rnd_ready = 0;
    OutReady = 1'b1;
    drain();
    chk("cnt_random", MisalignCnt, 64'(mdl_cnt));

    // Asynchronous reset with both stages occupied.
    OutReady = 1'b0;
    send(32'hAAAA5555, 2'd0, 2'd2, 1'b1, 5'd20);
    send(32'h5555AAAA, 2'd0, 2'd2, 1'b1, 5'd21);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_outvalid", OutValid, 0);
    chk("arst_inready", InReady, 1);
    sb.delete();
    mdl_cnt = 0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    OutReady = 1'b1;
    chk("arst_cnt", MisalignCnt, 0);
    send(32'hCAFEF00D, 2'd0, 2'd2, 1'b0, 5'd9);
    drain();

`ifdef LOAD_EXTEND_MISALIGN_CHECK_EN
    for (int i = 0; i < 32'hFFFF + 5; i++) send($urandom, 2'd1, 2'd1, 1'b0, 5'd3);
    drain();
    chk("cnt_saturate", MisalignCnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Pipelined load-data formatter for the memory-read path of the datapath. It takes a raw memory word, the access's low address bits, its size and its signedness. It extracts the addressed byte, halfword or word lane and sign- or zero-extends it to full width. It sits between data memory and the MEM/WB register. Unlike a purely combinational extender, it is parametrised in width, carries a tag, uses a valid/ready handshake with two register stages, and optionally checks alignment with a saturating error counter.

## Interface
Parameters:
- XLEN, 32: data width in bits; must be a power of two, at least 16.
- TAG_W, 5: width of the sideband tag (destination register index).
- CNT_W, 16: width of the misalignment counter.

Ports:
- Clk  in  1  rising-edge clock. The block uses one clock only.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  upstream has a request.
- InReady  out  1  the block can accept a request this cycle.
- InData  in  XLEN  raw memory word.
- InAddrLo  in  log2(XLEN/8)  byte offset within the word.
- InSize  in  2  access size as log2 of the byte count: 0 byte, 1 half, 2 word, 3 dword.
- InUnsigned  in  1  1 = zero-extend, 0 = sign-extend.
- InTag  in  TAG_W  sideband, passed through unchanged.
- OutValid  out  1  result available.
- OutReady  in  1  downstream accepts the result.
- OutData  out  XLEN  extended result.
- OutTag  out  TAG_W  tag of the result.
- OutMisalign  out  1  result came from a misaligned access.
- MisalignCnt  out  CNT_W  saturating count of misaligned accesses.

## Operation
- The block has two stages:
  - Stage A registers the raw request.
  - Stage B registers the formatted result and drives all Out* ports.
- Transfers:
  - An input transfer occurs when InValid && InReady.
  - An output transfer occurs when OutValid && OutReady.
- Ready propagation:
  - Stage B loads when B is empty or OutReady = 1.
  - Stage A loads when A is empty or B loads.
  - InReady = !A_valid || B_load. This is combinational from OutReady, with no cycle bubble.
- Formatting in the A→B path:
  - Shift InData right by InAddrLo × 8.
  - Keep the low 8 << InSize bits.
  - Fill the upper bits with the kept MSB when InUnsigned = 0, otherwise with 0.
- A size of at least log2(XLEN/8) is a full-width pass-through. InUnsigned and InAddrLo are ignored for it. For XLEN = 32, size 3 behaves as size 2.
- A misaligned access is one where InAddrLo is not a multiple of 1 << InSize, for sizes below full width.
- The block does not reorder, drop or duplicate requests. Tags leave in arrival order.
- While OutValid = 1 and OutReady = 0, OutData, OutTag and OutMisalign hold stable.

## Timing
- Reset values:
  - OutValid = 0, OutData = 0, OutTag = 0, OutMisalign = 0, MisalignCnt = 0.
  - Both stage valids = 0, so InReady = 1 while Rst_n = 0 and after release.
- Latency: a request accepted at edge N gives OutValid = 1 after edge N+1.
- Throughput: one result per cycle with OutReady held at 1.
- Backpressure with OutReady = 0:
  - B holds its result.
  - A accepts one more request, then InReady = 0.
  - When OutReady rises, A moves into B and a new input may be taken in the same cycle.
- Reset asserted mid-operation:
  - All in-flight entries are discarded immediately, without waiting for a clock edge.
  - No stale result appears after release.
- The counter increments when a misaligned result enters B. It saturates at all-ones and never wraps.

## Configuration
- Macro: LOAD_EXTEND_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned request produces OutMisalign = 1 and OutData = 0; its tag is passed through.
  - MisalignCnt increments.
- Undefined:
  - InAddrLo is masked down to the size alignment before the shift. A half at offset 3 is therefore read as offset 2.
  - OutMisalign and MisalignCnt are tied to 0.
  - The counter register is not synthesised.

## Structure
- Package load_extend_pkg holds:
  - the size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2, SZ_DWORD = 3;
  - the constant LANE_W = 8;
  - the function computing the log2(XLEN/8) offset width.
- One sub-module, load_extend_fmt: the combinational shift/mask/extend datapath plus the misalignment decode. It is instantiated between stage A and stage B.
- The handshake, stage registers and counter stay in the top module.

## Test plan
- Byte extraction, XLEN = 32, InData = 0x80F17F23:
  - offset 1, signed → 0x0000007F.
  - offset 2, signed → 0xFFFFFFF1.
  - offset 2, unsigned → 0x000000F1.
- Halfword extraction: offset 2, signed, same data → 0xFFFF80F1. Unsigned → 0x000080F1.
- Word and pass-through:
  - Word, offset 0, unsigned = 1 → 0x80F17F23 unchanged.
  - XLEN = 64, dword size → full pass-through.
- Backpressure stream:
  - Tags 0–3 back-to-back with OutReady low for 3 cycles.
  - InReady falls after 2 accepts.
  - Outputs are tags 0,1,2,3 in order with data intact, none lost or duplicated.
- Misalignment: half at offset 3 with data 0x12345678.
  - With the macro: OutMisalign = 1, OutData = 0, MisalignCnt = 1. After 0xFFFF + 5 misaligned requests with CNT_W = 16, the count holds 0xFFFF.
  - Without the macro: OutData = 0x00001234 (signed).
- Asynchronous reset: drive Rst_n low between edges with both stages full → OutValid = 0 immediately and InReady = 1. After release, the first output is the first post-reset request.
